regfile64_n: RTL and testbench
==============================

REGFILE64_N -- requirements
Module: regfile64_n

Interface
REQ-001 SHALL provide parameter: n, default 4, data width of each entry in bits.
REQ-002 SHALL provide parameter: address, default 6, address width; depth is 2**address = 64.
REQ-003 SHALL have port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: we_i  input  1  write enable.
REQ-006 SHALL have port: waddr_i  input  address  write address.
REQ-007 SHALL have port: wdata_i  input  n  write data.
REQ-008 SHALL have port: clr_i  input  1  start bulk clear (sampled only in IDLE).
REQ-009 SHALL have port: data_o  output  n x [0:2**address-1]  unpacked array of all stored entries; feeds the 64:1 read-select stage downstream.
REQ-010 SHALL have port: busy_o  output  1  high while a bulk clear is in progress.
REQ-011 SHALL have port: done_o  output  1  one-cycle pulse when a bulk clear completes.
REQ-012 SHALL have port: drop_o  output  1  one-cycle pulse when a requested write was discarded.

Function
REQ-013 SHALL write wdata_i into entry waddr_i at the clock edge where we_i=1 and the FSM is IDLE and clr_i=0; data_o[waddr_i] SHALL show the new value in the following cycle (1-cycle latency).
REQ-014 SHALL drive data_o directly from storage flops, with no combinational path from any input to data_o.
REQ-015 SHALL implement FSM states IDLE and CLEAR; IDLE->CLEAR when clr_i=1; CLEAR->IDLE after the entry at index 63 is cleared.
REQ-016 In CLEAR, SHALL zero one entry per cycle at index cnt, starting at cnt=0 and incrementing to 63 (64 cycles total); cnt SHALL return to 0 on exit.
REQ-017 SHALL hold busy_o=1 in every CLEAR cycle and 0 in IDLE.
REQ-018 SHALL pulse done_o=1 in the first IDLE cycle after the CLEAR->IDLE transition.
REQ-019 Simultaneous we_i=1 and clr_i=1 in IDLE: clear SHALL win, write SHALL be discarded, drop_o SHALL pulse next cycle.
REQ-020 we_i=1 during CLEAR: write SHALL be discarded, drop_o SHALL pulse next cycle.
REQ-021 clr_i=1 during CLEAR SHALL be ignored (no restart, no extension).
REQ-022 Entries not yet reached by an active clear SHALL keep their prior values.

Reset
REQ-023 rst_i=1 SHALL set all 64 entries to 0, FSM to IDLE, cnt to 0, and busy_o, done_o and drop_o to 0 at the next edge.
REQ-024 rst_i SHALL take priority over we_i and clr_i, including when asserted mid-clear; the FSM SHALL abort to IDLE without pulsing done_o.

Configuration
REQ-025 Macro REGFILE64_ZERO0_EN, when defined: entry 0 SHALL read as constant 0, and writes to address 0 SHALL be discarded without pulsing drop_o.
REQ-026 Macro REGFILE64_ZERO0_EN, when undefined: entry 0 SHALL behave as any other entry.

Structure
REQ-027 Package regfile64_pkg SHALL hold the ADDRESS=6 and DEPTH=64 constants and the FSM state enum (IDLE, CLEAR).
REQ-028 The write-enable one-hot decode SHALL be a sub-module decoder6to64 (6-bit address plus enable in, 64-bit one-hot out).

Verification
REQ-029 Reset, then write 4'hA to addr 5 -> data_o[5]=4'hA one cycle later; all other entries remain 0.
REQ-030 Fill all 64 entries with their index, assert clr_i for 1 cycle -> busy_o high for 64 cycles, data_o[k] becomes 0 at cycle k+1 after the start, then done_o pulses once and busy_o=0.
REQ-031 we_i=1 with clr_i=1 in IDLE (addr 3, 4'h7) -> data_o[3] stays 0 after clear, drop_o pulses once.
REQ-032 we_i=1 to addr 63 at clear cycle 10 -> write discarded, drop_o pulses; data_o[63]=0 at end of clear.
REQ-033 rst_i asserted at clear cycle 20 -> next cycle busy_o=0, all entries 0, done_o never pulses.
REQ-034 With REGFILE64_ZERO0_EN defined, write 4'hF to addr 0 -> data_o[0]=0, drop_o stays 0; without the macro -> data_o[0]=4'hF.

Source files
------------

// File: rtl/regfile64_pkg.sv
// rtl/regfile64_pkg.sv - shared constants and FSM state type for regfile64_n
package regfile64_pkg;

  localparam int ADDRESS = 6;
  localparam int DEPTH   = 2 ** ADDRESS;

  // Last index visited by a bulk clear, sized to the clear counter
  localparam logic [ADDRESS-1:0] CNT_LAST = ADDRESS'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/regfile64_n_decoder6to64.sv
// rtl/regfile64_n_decoder6to64.sv - 6-bit address to 64-bit one-hot write-enable decode
module decoder6to64
  import regfile64_pkg::*;
(
  input  logic [ADDRESS-1:0] addr_i,
  input  logic               en_i,
  output logic [DEPTH-1:0]   onehot_o
);

  // Exactly one bit set when enabled, all zero otherwise
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o = DEPTH'(1) << addr_i;
  end

endmodule

// File: rtl/regfile64_n.sv
// rtl/regfile64_n.sv - 64-entry register file with sequenced bulk clear (option: REGFILE64_ZERO0_EN)
module regfile64_n
  import regfile64_pkg::*;
#(
  parameter int n       = 4,
  parameter int address = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [address-1:0] waddr_i,
  input  logic [n-1:0]       wdata_i,
  input  logic               clr_i,
  output logic [n-1:0]       data_o [0:2**address-1],
  output logic               busy_o,
  output logic               done_o,
  output logic               drop_o
);

  state_e             state_q, state_d;
  logic [ADDRESS-1:0] cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               drop_q, drop_d;
  logic               wr_en;
  logic [DEPTH-1:0]   wr_onehot;
  logic [DEPTH-1:0]   wr_mask;
  logic [n-1:0]       mem_q [0:DEPTH-1];

  // A write lands only when idle and not pre-empted by a clear request
  assign wr_en = we_i && (state_q == IDLE) && !clr_i;

  decoder6to64 u_dec (
    .addr_i   (waddr_i),
    .en_i     (wr_en),
    .onehot_o (wr_onehot)
  );

`ifdef REGFILE64_ZERO0_EN
  // Entry 0 is hardwired to zero, so its enable is never allowed through
  assign wr_mask = {wr_onehot[DEPTH-1:1], 1'b0};
`else
  assign wr_mask = wr_onehot;
`endif

  // FSM next state, clear counter and one-cycle status pulses
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
          drop_d  = we_i;
        end
      end
      CLEAR: begin
        drop_d = we_i;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter and pulse registers; reset aborts a clear with no done pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  // Storage: reset zeroes everything, clear zeroes one entry per cycle, else decoded writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_mask[i]) mem_q[i] <= wdata_i;
      end
    end
  end

  assign data_o = mem_q;
  assign busy_o = (state_q == CLEAR);
  assign done_o = done_q;
  assign drop_o = drop_q;

endmodule

// File: tb/tb_regfile64_n.sv
// tb/tb_regfile64_n.sv - directed self-checking bench for regfile64_n
module tb_regfile64_n;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we = 1'b0;
  logic [5:0] waddr = '0;
  logic [3:0] wdata = '0;
  logic       clr = 1'b0;
  logic [3:0] data [0:63];
  logic       busy, done, drop;

  int vectors = 0;
  int miscompares = 0;

  regfile64_n #(.n(4), .address(6)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .clr_i   (clr),
    .data_o  (data),
    .busy_o  (busy),
    .done_o  (done),
    .drop_o  (drop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int bad;
    int busy_cnt, done_cnt, drop_cnt;
    int exp0;

    // Reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_drop", drop, 0);
    chk("rst_d0", data[0], 0);
    chk("rst_d63", data[63], 0);

    // Single write, 1-cycle latency, neighbours untouched
    we = 1'b1; waddr = 6'd5; wdata = 4'hA;
    step();
    we = 1'b0;
    chk("wr5", data[5], 10);
    bad = 0;
    for (int k = 0; k < 64; k++) if (k != 5 && data[k] !== 4'h0) bad++;
    chk("wr5_others_zero", bad, 0);
    chk("wr5_drop", drop, 0);

    // Fill all entries with index
    for (int k = 0; k < 64; k++) begin
      we = 1'b1; waddr = 6'(k); wdata = 4'(k);
      step();
    end
    we = 1'b0;
`ifdef REGFILE64_ZERO0_EN
    exp0 = 0;
`else
    exp0 = 0;
`endif
    chk("fill_d0", data[0], exp0);
    chk("fill_d37", data[37], 5);
    chk("fill_d63", data[63], 15);

    // Bulk clear: write at cycle 10 dropped, clr re-asserted at cycle 30 ignored
    clr = 1'b1;
    step();
    clr = 1'b0;
    busy_cnt = 0; done_cnt = 0; drop_cnt = 0; bad = 0;
    for (int c = 0; c < 64; c++) begin
      if (busy === 1'b1) busy_cnt++;
      if (c < 63 && data[c+1] !== 4'(c + 1)) bad++;
      we  = (c == 10);
      waddr = 6'd63; wdata = 4'h9;
      clr = (c == 30);
      step();
      if (data[c] !== 4'h0) bad++;
      if (drop === 1'b1) drop_cnt++;
      if (done === 1'b1) done_cnt++;
    end
    we = 1'b0; clr = 1'b0;
    chk("clr_busy_cycles", busy_cnt, 64);
    chk("clr_progress", bad, 0);
    chk("clr_drop_once", drop_cnt, 1);
    chk("clr_done_once", done_cnt, 1);
    chk("clr_done_now", done, 1);
    chk("clr_busy_after", busy, 0);
    chk("clr_d63", data[63], 0);
    step();
    chk("clr_done_pulse_end", done, 0);

    // Write colliding with clear request in IDLE
    we = 1'b1; waddr = 6'd3; wdata = 4'h7; clr = 1'b1;
    step();
    we = 1'b0; clr = 1'b0;
    chk("coll_drop", drop, 1);
    chk("coll_busy", busy, 1);
    drop_cnt = 0;
    for (int c = 0; c < 64; c++) begin
      step();
      if (drop === 1'b1) drop_cnt++;
    end
    chk("coll_drop_single", drop_cnt, 0);
    chk("coll_done", done, 1);
    chk("coll_d3", data[3], 0);

    // Reset mid-clear at cycle 20
    we = 1'b1; waddr = 6'd40; wdata = 4'hC;
    step();
    we = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int c = 0; c < 20; c++) step();
    chk("abort_busy_before", busy, 1);
    chk("abort_d40_untouched", data[40], 12);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_d40", data[40], 0);
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 70; c++) begin
      step();
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_busy", busy_cnt, 0);

    // Address 0 write
    we = 1'b1; waddr = 6'd0; wdata = 4'hF;
    step();
    we = 1'b0;
`ifdef REGFILE64_ZERO0_EN
    chk("a0_data", data[0], 0);
`else
    chk("a0_data", data[0], 15);
`endif
    chk("a0_drop", drop, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
